// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory access arbiter: instruction opcodes, arbiter state
// encoding and the requester-count bound.
package mem_access_arbiter_pkg;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        FENCE = 2'd3
    } inst_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_REQ = 16;

    // Index width for n requesters, never narrower than one bit.
    function automatic int arb_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_arb_pick.sv
// Combinational winner selection for the memory access arbiter.
// ARB_ROUND_ROBIN_EN selects rotating priority; otherwise the lowest index wins.
module arb_pick
    import mem_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int SEL_W  = arb_sel_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   win_idx,
    output logic               win_vld
);

`ifdef ARB_ROUND_ROBIN_EN
    // Search begins one past the last owner and wraps, so the last owner ranks lowest.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int d = 1; d <= NUM_REQ; d++) begin
            idx  = (int'(ptr) + d) % NUM_REQ;
            cand = SEL_W'(idx);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        logic [SEL_W-1:0] cand;
        cand    = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = SEL_W'(i);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one memory read/write port between NUM_REQ controllers; holds the strobe for
// WAIT_CYCLES then pulses done. Build option: ARB_ROUND_ROBIN_EN (see arb_pick).
//
// state  | meaning
// IDLE   | port free, arbitrating among raised requests
// ACCESS | owner's strobe held while the wait counter runs down to 0
// DONE   | one-cycle completion pulse to the owner, priority pointer moves
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WAIT_CYCLES = 2,
    localparam int SEL_W      = arb_sel_w(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  inst_t              op [NUM_REQ],
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               mem_read,
    output logic               mem_write,
    output logic [SEL_W-1:0]   mem_sel,
    output logic               busy
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    arb_state_t         state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    inst_t              op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [SEL_W-1:0]   mem_sel_q, mem_sel_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   win_idx;
    logic               win_vld;

    arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ACCESS;
                    owner_d = win_idx;
                    op_d    = op[win_idx];
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = owner_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next-state registers so they land on the same edge.
    always_comb begin
        grant_d     = '0;
        done_d      = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_sel_d   = '0;
        busy_d      = (state_d != IDLE);

        if (state_d != IDLE) begin
            grant_d[owner_d] = 1'b1;
            mem_sel_d        = owner_d;
        end
        if (state_d == ACCESS) begin
            mem_read_d  = (op_d == FETCH);
            mem_write_d = (op_d == WRITE);
        end
        if (state_d == DONE) begin
            done_d[owner_d] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            op_q        <= NOP;
            cnt_q       <= '0;
            ptr_q       <= SEL_W'(NUM_REQ - 1);
            grant_q     <= '0;
            done_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_sel_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_sel_q   <= mem_sel_d;
            busy_q      <= busy_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_sel   = mem_sel_q;
    assign busy      = busy_q;

endmodule
